// File: rtl/gate_drv_pkg.sv
// Shared types and arithmetic helpers for the gate-drive sequencer.
// The state encoding is exported on state_o, so it must stay stable.
package gate_drv_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    RAMP      = 3'd2,
    RUN       = 3'd3,
    STOPPING  = 3'd4,
    FAULT     = 3'd5
  } gd_state_t;

  // Clamp a signed value into [0, hi]; keeps duty math from wrapping.
  function automatic int sat_range(input int v, input int hi);
    if (v < 0) begin
      return 0;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  // Move cur toward tgt by at most step, landing exactly on tgt when closer than step.
  function automatic int step_toward(input int cur, input int tgt, input int step);
    int diff;
    int mag;
    int delta;
    diff  = tgt - cur;
    mag   = (diff < 0) ? -diff : diff;
    delta = (mag < step) ? mag : step;
    return (diff < 0) ? (cur - delta) : (cur + delta);
  endfunction

endpackage

// File: rtl/duty_stepper.sv
// Combinational duty stepper: one bounded step from cur toward tgt.
// Shared by RAMP (step up to target), RUN (slew) and STOPPING (step to zero).
module duty_stepper
  import gate_drv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] cur,
  input  logic [N-1:0] tgt,
  input  logic [N-1:0] step,
  output logic [N-1:0] nxt
);

  localparam int DMAX = (1 << N) - 1;

  logic signed [N+1:0] cur_s;
  logic signed [N+1:0] tgt_s;
  logic signed [N+1:0] step_s;
  logic signed [N+1:0] raw_s;

  // Widen to signed, take the bounded step, then saturate back to N bits.
  always_comb begin
    cur_s  = $signed({2'b00, cur});
    tgt_s  = $signed({2'b00, tgt});
    step_s = $signed({2'b00, step});
    raw_s  = (N+2)'(step_toward(int'(cur_s), int'(tgt_s), int'(step_s)));
    nxt    = N'(sat_range(int'(raw_s), DMAX));
  end

endmodule

// File: rtl/gate_drive_sequencer.sv
// Gate-drive sequencer for one PWM channel: bootstrap precharge, soft-start
// ramp, slew-limited run, soft stop and a latched fault. Duty only changes on
// the last cycle of a PWM period so the downstream PWM never sees a mid-period
// step; fault entry is the exception and kills the drive immediately.
module gate_drive_sequencer
  import gate_drv_pkg::*;
#(
  parameter int N                 = 8,
  parameter int PERIOD_CYCLES     = 256,
  parameter int PRECHARGE_PERIODS = 16,
  parameter int RAMP_STEP         = 1,
  parameter int SLEW_STEP         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         fault_in,
  input  logic         fault_clear,
  input  logic [N-1:0] target_duty,
  output logic         pwm_ena,
  output logic [N-1:0] pwm_duty,
  output logic         period_end,
  output gd_state_t    state_o,
  output logic         fault_latched
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int PC_W  = $clog2(PRECHARGE_PERIODS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_LOAD     = PC_W'(PRECHARGE_PERIODS);
  localparam logic [PC_W-1:0]  PC_ONE      = PC_W'(1);
  localparam logic [N-1:0]     RAMP_STEP_N = N'(RAMP_STEP);
  localparam logic [N-1:0]     SLEW_STEP_N = N'(SLEW_STEP);

  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  pc_cnt;
  logic             tick;

  gd_state_t        state_q;
  gd_state_t        state_d;

  logic [N-1:0]     step_tgt;
  logic [N-1:0]     step_amt;
  logic [N-1:0]     step_nxt;
  logic [N-1:0]     duty_d;
  logic             ena_d;
  logic             driving_q;

  assign tick          = (cnt == CNT_LAST);
  assign period_end    = tick;
  assign state_o       = state_q;
  assign fault_latched = (state_q == FAULT);
  assign driving_q     = (state_q == RAMP) || (state_q == RUN) || (state_q == STOPPING);

  // Free-running period counter; its last count is the duty-update tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Precharge period counter: loaded on entry, counts ticks down while precharging.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_cnt <= '0;
    end else if ((state_q == IDLE) && (state_d == PRECHARGE)) begin
      pc_cnt <= PC_LOAD;
    end else if ((state_q == PRECHARGE) && tick && (pc_cnt != '0)) begin
      pc_cnt <= pc_cnt - PC_ONE;
    end
  end

  // Stepper operands: STOPPING heads for zero, RUN uses the slew limit, RAMP the ramp step.
  always_comb begin
    step_tgt = (state_q == STOPPING) ? '0 : target_duty;
    step_amt = (state_q == RUN) ? SLEW_STEP_N : RAMP_STEP_N;
  end

  duty_stepper #(
    .N(N)
  ) u_stepper (
    .cur  (pwm_duty),
    .tgt  (step_tgt),
    .step (step_amt),
    .nxt  (step_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fault_in overrides everything except reset, stop beats start.
  always_comb begin
    state_d = state_q;
    if (fault_in) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) state_d = PRECHARGE;
        end
        PRECHARGE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick && (pc_cnt == PC_ONE)) begin
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (stop) begin
            state_d = STOPPING;
          end else if (tick && (step_nxt == target_duty)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) state_d = STOPPING;
        end
        STOPPING: begin
          if (tick && (pwm_duty == '0)) state_d = IDLE;
        end
        FAULT: begin
          if (fault_clear) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: drive only in the active states, step duty only on ticks.
  always_comb begin
    ena_d  = 1'b0;
    duty_d = '0;
    case (state_d)
      RAMP, RUN, STOPPING: begin
        ena_d  = 1'b1;
        duty_d = pwm_duty;
        if (tick && driving_q) duty_d = step_nxt;
      end
      default: begin
        ena_d  = 1'b0;
        duty_d = '0;
      end
    endcase
  end

  // Registered PWM controls so the generator sees glitch-free inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_ena  <= 1'b0;
      pwm_duty <= '0;
    end else begin
      pwm_ena  <= ena_d;
      pwm_duty <= duty_d;
    end
  end

endmodule

// File: tb/tb_gate_drive_sequencer.sv
// Directed bench for gate_drive_sequencer with short periods and precharge.
module tb_gate_drive_sequencer;
  import gate_drv_pkg::*;

  localparam int N  = 8;
  localparam int PC = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         fault_in;
  logic         fault_clear;
  logic [N-1:0] target_duty;
  logic         pwm_ena;
  logic [N-1:0] pwm_duty;
  logic         period_end;
  gd_state_t    state_o;
  logic         fault_latched;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gate_drive_sequencer #(
    .N                 (N),
    .PERIOD_CYCLES     (PC),
    .PRECHARGE_PERIODS (2),
    .RAMP_STEP         (1),
    .SLEW_STEP         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .fault_in      (fault_in),
    .fault_clear   (fault_clear),
    .target_duty   (target_duty),
    .pwm_ena       (pwm_ena),
    .pwm_duty      (pwm_duty),
    .period_end    (period_end),
    .state_o       (state_o),
    .fault_latched (fault_latched)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input gd_state_t st, input logic ena, input int duty);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_ena"}, 32'(pwm_ena), 32'(ena));
    chk({tag, "_duty"}, 32'(pwm_duty), 32'(duty));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance through the next tick edge and settle just after it.
  task automatic next_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PC; i++) begin
      @(negedge clk);
      if (period_end) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("tick_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int exp_up[5]   = '{7, 11, 15, 19, 20};
  int exp_dn[3]   = '{16, 12, 10};
  int exp_stop[5] = '{4, 3, 2, 1, 0};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault_in = 1'b0; fault_clear = 1'b0;
    target_duty = '0;
    cyc(3);
    chk_out("reset", IDLE, 1'b0, 0);
    chk("reset_latched", 32'(fault_latched), 32'd0);
    chk("reset_pend", 32'(period_end), 32'd0);

    // Soft start to duty 3
    rst = 1'b0; start = 1'b1; target_duty = 8'd3;
    cyc(1);
    chk_out("pre0", PRECHARGE, 1'b0, 0);
    next_tick();
    chk_out("pre1", PRECHARGE, 1'b0, 0);
    next_tick();
    chk_out("ramp0", RAMP, 1'b1, 0);
    next_tick();
    chk_out("ramp1", RAMP, 1'b1, 1);
    next_tick();
    chk_out("ramp2", RAMP, 1'b1, 2);
    next_tick();
    chk_out("ramp3", RUN, 1'b1, 3);
    start = 1'b0;

    // Slew-limited run up and down
    target_duty = 8'd20;
    for (int i = 0; i < 5; i++) begin
      next_tick();
      chk_out("slew_up", RUN, 1'b1, exp_up[i]);
    end
    target_duty = 8'd10;
    for (int i = 0; i < 3; i++) begin
      next_tick();
      chk_out("slew_dn", RUN, 1'b1, exp_dn[i]);
    end
    target_duty = 8'd5;
    next_tick();
    chk("slew_6", 32'(pwm_duty), 32'd6);
    next_tick();
    chk("slew_5", 32'(pwm_duty), 32'd5);

    // Soft stop from duty 5
    stop = 1'b1;
    cyc(1);
    chk_out("stop_entry", STOPPING, 1'b1, 5);
    for (int i = 0; i < 5; i++) begin
      next_tick();
      chk_out("stopping", STOPPING, 1'b1, exp_stop[i]);
    end
    next_tick();
    chk_out("stop_idle", IDLE, 1'b0, 0);
    stop = 1'b0;

    // Fault mid-period during RAMP
    start = 1'b1; target_duty = 8'd50;
    cyc(1);
    start = 1'b0;
    next_tick();
    next_tick();
    next_tick();
    chk_out("f_ramp", RAMP, 1'b1, 1);
    cyc(3);
    fault_in = 1'b1;
    cyc(1);
    chk_out("f_entry", FAULT, 1'b0, 0);
    chk("f_latched", 32'(fault_latched), 32'd1);
    fault_clear = 1'b1;
    cyc(1);
    chk("f_clr_blocked", 32'(state_o), 32'(FAULT));
    fault_clear = 1'b0; fault_in = 1'b0;
    cyc(1);
    chk("f_hold", 32'(fault_latched), 32'd1);
    fault_clear = 1'b1;
    cyc(1);
    chk_out("f_exit", IDLE, 1'b0, 0);
    chk("f_unlatched", 32'(fault_latched), 32'd0);
    fault_clear = 1'b0;

    // Full-scale ramp must saturate at 255
    start = 1'b1; target_duty = 8'd255;
    cyc(1);
    start = 1'b0;
    for (int k = 0; k < 300 && (state_o != RUN); k++) next_tick();
    chk_out("sat_run", RUN, 1'b1, 255);
    next_tick();
    next_tick();
    chk("sat_hold", 32'(pwm_duty), 32'd255);

    // Reset in RUN
    rst = 1'b1;
    cyc(1);
    chk_out("rst_run", IDLE, 1'b0, 0);
    chk("rst_pend", 32'(period_end), 32'd0);
    chk("rst_latched", 32'(fault_latched), 32'd0);
    rst = 1'b0;

    // Zero target: RAMP -> RUN on the first tick
    start = 1'b1; target_duty = 8'd0;
    cyc(1);
    start = 1'b0;
    next_tick();
    next_tick();
    chk_out("z_ramp", RAMP, 1'b1, 0);
    next_tick();
    chk_out("z_run", RUN, 1'b1, 0);
    stop = 1'b1;
    cyc(1);
    chk("z_stopping", 32'(state_o), 32'(STOPPING));
    next_tick();
    chk_out("z_idle", IDLE, 1'b0, 0);
    stop = 1'b0;

    // start and fault_in together in IDLE
    start = 1'b1; fault_in = 1'b1;
    cyc(1);
    chk_out("sf_fault", FAULT, 1'b0, 0);
    start = 1'b0; fault_in = 1'b0; fault_clear = 1'b1;
    cyc(1);
    chk("sf_clear", 32'(state_o), 32'(IDLE));
    fault_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
